// File: rtl/vga_timing_if.sv
// Sync pins in, recovered pixel coordinates and link status out.
interface vga_timing_if;
  logic       hsync_n;
  logic       vsync_n;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       frame_start;
  logic       locked;
  logic       err;

  modport master (
    output hsync_n, vsync_n,
    input  x, y, active, frame_start, locked, err
  );

  modport slave (
    input  hsync_n, vsync_n,
    output x, y, active, frame_start, locked, err
  );
endinterface

// File: rtl/vga_timing_decoder.sv
// Recovers pixel coordinates from negative-polarity VGA syncs, checks every sample against
// the predicted sync pattern and tracks lock.
module vga_timing_decoder #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned H_FPORCH    = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BPORCH    = 48,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned V_FPORCH    = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BPORCH    = 33,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic         clk_i,
  input logic         rst_i,
  vga_timing_if.slave vid_io
);

  localparam int unsigned HTotal = H_RES + H_FPORCH + H_SYNC + H_BPORCH;
  localparam int unsigned VTotal = V_RES + V_FPORCH + V_SYNC + V_BPORCH;
  localparam logic [9:0] XLast   = 10'(HTotal - 1);
  localparam logic [9:0] YLast   = 10'(VTotal - 1);
  localparam logic [9:0] HsBegin = 10'(H_RES + H_FPORCH - 1);
  localparam logic [9:0] HsEnd   = 10'(H_RES + H_FPORCH - 1 + H_SYNC);
  localparam logic [9:0] VsBegin = 10'(V_RES + V_FPORCH - 1);
  localparam logic [9:0] VsEnd   = 10'(V_RES + V_FPORCH - 1 + V_SYNC);
  localparam logic [9:0] HRes    = 10'(H_RES);
  localparam logic [9:0] VRes    = 10'(V_RES);
  localparam int unsigned CntW   = $clog2(LOCK_FRAMES + 1) + 2;
  localparam logic [CntW-1:0] LockCnt = CntW'(LOCK_FRAMES);

  typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

  state_e          state_q, state_d;
  logic            rh_q, rv_q, ph_q, pv_q;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [CntW-1:0] clean_q, clean_d;
  logic            dirty_q, dirty_d;
  logic            active_q, active_d;
  logic            frame_start_q, frame_start_d;
  logic            err_q, err_d;

  logic            fall_h, fall_v, x_wrap, exph, expv, mismatch, realign;
  logic [9:0]      px, py;

  // Prediction of the next coordinate and the sync levels the pins should show for it.
  always_comb begin
    fall_h   = ph_q & ~rh_q;
    fall_v   = pv_q & ~rv_q;
    x_wrap   = (x_q == XLast);
    px       = x_wrap ? '0 : x_q + 10'd1;
    py       = y_q;
    if (x_wrap) begin
      py = (y_q == YLast) ? '0 : y_q + 10'd1;
    end
    exph     = ~((px >= HsBegin) && (px < HsEnd));
    expv     = ~((py >= VsBegin) && (py < VsEnd));
    mismatch = (rh_q != exph) || (rv_q != expv);
  end

  always_comb begin
    state_d = state_q;
    x_d     = px;
    y_d     = py;
    clean_d = clean_q;
    dirty_d = dirty_q;
    err_d   = 1'b0;
    realign = (state_q == StUnlocked) || mismatch;

    unique case (state_q)
      StUnlocked: begin
        if (mismatch) begin
          clean_d = '0;
          dirty_d = 1'b1;
        end
        // A sync fall starts a fresh frame; only a fully clean previous frame counts.
        if (fall_v) begin
          if (!dirty_q && !mismatch) begin
            clean_d = clean_q + CntW'(1);
          end
          dirty_d = 1'b0;
        end
        if (clean_d >= LockCnt) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (mismatch) begin
          err_d   = 1'b1;
          clean_d = '0;
          dirty_d = 1'b1;
          state_d = StUnlocked;
        end
      end
    endcase

    if (realign && fall_h) begin
      x_d = HsBegin;
    end
    if (realign && fall_v) begin
      y_d = VsBegin;
    end

    active_d      = (state_d == StLocked) && (x_d < HRes) && (y_d < VRes);
    frame_start_d = (state_d == StLocked) && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StUnlocked;
      rh_q          <= 1'b1;
      rv_q          <= 1'b1;
      ph_q          <= 1'b1;
      pv_q          <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      clean_q       <= '0;
      dirty_q       <= 1'b0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rh_q          <= vid_io.hsync_n;
      rv_q          <= vid_io.vsync_n;
      ph_q          <= rh_q;
      pv_q          <= rv_q;
      x_q           <= x_d;
      y_q           <= y_d;
      clean_q       <= clean_d;
      dirty_q       <= dirty_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
    end
  end

  assign vid_io.x           = x_q;
  assign vid_io.y           = y_q;
  assign vid_io.active      = active_q;
  assign vid_io.frame_start = frame_start_q;
  assign vid_io.locked      = (state_q == StLocked);
  assign vid_io.err         = err_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench: a reduced-size timing generator drives the decoder through lock, glitch,
// phase-jump and reset scenarios.
module tb_vga_timing_decoder;

  localparam int HR = 16, HFP = 4, HSW = 6, HBP = 6;
  localparam int VR = 12, VFP = 2, VSW = 2, VBP = 4;
  localparam int HT = HR + HFP + HSW + HBP;   // 32
  localparam int VT = VR + VFP + VSW + VBP;   // 20
  localparam int HSB = HR + HFP - 1;          // 19
  localparam int HSE = HSB + HSW;             // 25
  localparam int VSB = VR + VFP - 1;          // 13
  localparam int VSE = VSB + VSW;             // 15
  localparam int FRAME = HT * VT;             // 640

  logic clk;
  logic rst;
  vga_timing_if vid_if ();

  vga_timing_decoder #(
    .H_RES(HR), .H_FPORCH(HFP), .H_SYNC(HSW), .H_BPORCH(HBP),
    .V_RES(VR), .V_FPORCH(VFP), .V_SYNC(VSW), .V_BPORCH(VBP),
    .LOCK_FRAMES(2)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .vid_io (vid_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int gx, gy;          // generator coordinate currently on the pins
  int cap_x, cap_y;    // generator coordinate at the previous rising edge
  int ex, ey;          // coordinate the DUT must show now
  bit force_h  = 1'b0;
  bit gen_jump = 1'b0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({vid_if.x, vid_if.y, vid_if.active, vid_if.frame_start,
                 vid_if.locked, vid_if.err});
  endfunction

  task automatic drive_pins();
    vid_if.hsync_n = force_h | !(gx >= HSB && gx < HSE);
    vid_if.vsync_n = !(gy >= VSB && gy < VSE);
  endtask

  // One pixel clock: sample after the rising edge, advance the generator on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    ex    = cap_x;
    ey    = cap_y;
    cap_x = gx;
    cap_y = gy;
    @(negedge clk);
    if (gen_jump) begin
      gx = 0;
      gy = 0;
    end else if (gx == HT - 1) begin
      gx = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end else begin
      gx = gx + 1;
    end
    drive_pins();
  endtask

  task automatic wait_lock(input string tag);
    int nfv  = 0;
    int errs = 0;
    bit got  = 1'b0;
    for (int i = 0; i < 6 * FRAME && !got; i++) begin
      step();
      if (ex == 0 && ey == VSB) nfv++;
      if (vid_if.err) errs++;
      if (vid_if.locked) got = 1'b1;
    end
    check_eq({tag, "_locked"}, int'(got), 1);
    check_eq({tag, "_nfv"}, nfv, 3);
    check_eq({tag, "_lock_x"}, int'(vid_if.x), 0);
    check_eq({tag, "_lock_y"}, int'(vid_if.y), VSB);
    check_eq({tag, "_err_unlocked"}, errs, 0);
  endtask

  task automatic track(input string tag, input int nframes);
    int bad = 0, act = 0, fs = 0, fs_off = 0, errs = 0;
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (ex == 0 && ey == 0) found = 1'b1;
    end
    check_eq({tag, "_sof_found"}, int'(found), 1);
    for (int c = 0; c < nframes * FRAME; c++) begin
      if (c != 0) step();
      if (int'(vid_if.x) != ex || int'(vid_if.y) != ey || !vid_if.locked) bad++;
      if (vid_if.active != (ex < HR && ey < VR)) bad++;
      if (vid_if.active) act++;
      if (vid_if.frame_start) begin
        fs++;
        if (ex != 0 || ey != 0) fs_off++;
      end
      if (vid_if.err) errs++;
      if ((c + 1) % FRAME == 0) begin
        check_eq($sformatf("%s_f%0d_track", tag, c / FRAME), bad, 0);
        check_eq($sformatf("%s_f%0d_active", tag, c / FRAME), act, HR * VR);
        check_eq($sformatf("%s_f%0d_fs", tag, c / FRAME), fs, 1);
        check_eq($sformatf("%s_f%0d_fs_pos", tag, c / FRAME), fs_off, 0);
        check_eq($sformatf("%s_f%0d_err", tag, c / FRAME), errs, 0);
        bad = 0; act = 0; fs = 0; fs_off = 0; errs = 0;
      end
    end
  endtask

  task automatic run_until_gen(input int tx, input int ty, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (gx == tx && gy == ty) found = 1'b1;
      else step();
    end
    check_eq({tag, "_reach"}, int'(found), 1);
  endtask

  task automatic wait_err(input string tag, output int err_x);
    bit got = 1'b0;
    err_x = -1;
    for (int i = 0; i < 2 * HT && !got; i++) begin
      step();
      if (vid_if.err) begin
        got   = 1'b1;
        err_x = ex;
        check_eq({tag, "_locked_at_err"}, int'(vid_if.locked), 0);
      end
    end
    check_eq({tag, "_err_seen"}, int'(got), 1);
  endtask

  task automatic wait_realign(input string tag, input int line);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (ex == HSB && (line < 0 || ey == line)) found = 1'b1;
    end
    check_eq({tag, "_realign_seen"}, int'(found), 1);
    check_eq({tag, "_realign_x"}, int'(vid_if.x), HSB);
  endtask

  initial begin
    int err_x;
    rst = 1'b1;
    vid_if.hsync_n = 1'b1;
    vid_if.vsync_n = 1'b1;
    cap_x = -1;
    cap_y = -1;
    gx = 0;
    gy = 0;

    // Reset held with the pins toggling.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("rst_hold%0d", i), outs(), 0);
      @(negedge clk);
      vid_if.hsync_n = 1'($urandom_range(0, 1));
      vid_if.vsync_n = 1'($urandom_range(0, 1));
    end
    rst = 1'b0;
    gx = 10;
    gy = 5;
    drive_pins();

    wait_lock("boot");
    track("boot", 3);

    // One-sample hsync glitch in the middle of the sync pulse.
    run_until_gen(HSB + 2, 3, "glitch");
    force_h = 1'b1;
    step();
    force_h = 1'b0;
    wait_err("glitch", err_x);
    check_eq("glitch_err_x", err_x, HSB + 3);
    wait_realign("glitch", 4);
    wait_lock("glitch");
    track("glitch", 1);

    // Generator phase jump back to (0,0) mid-frame.
    run_until_gen(9, 8, "jump");
    gen_jump = 1'b1;
    step();
    gen_jump = 1'b0;
    wait_err("jump", err_x);
    wait_realign("jump", -1);
    wait_lock("jump");
    track("jump", 1);

    // Single-cycle reset while locked.
    run_until_gen(5, 8, "mrst");
    rst = 1'b1;
    step();
    check_eq("mrst_outs", outs(), 0);
    rst = 1'b0;
    wait_lock("mrst");
    track("mrst", 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
